// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC, assembles one- and two-word instructions
// from a combinational instruction memory, and drives the IF/ID pipeline register.
module fetch_stage #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [15:0]     NOP_WORD = 16'hF800
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            stall,
  input  logic            flush,
  input  logic [PC_W-1:0] branch_target,
  output logic [15:0]     ifid_instr,
  output logic [15:0]     ifid_imm,
  output logic [PC_W-1:0] ifid_pc,
  output logic            ifid_valid
);

  typedef enum logic [0:0] {StFetch1, StFetch2} state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;
  logic [15:0]     hold_q;
  logic [15:0]     instr_q;
  logic [15:0]     imm_q;
  logic [PC_W-1:0] ifid_pc_q;
  logic            valid_q;
  logic            two_word;

  // Natural overflow gives the modulo-2^PC_W wrap at the top address.
  assign pc_inc    = pc_q + PC_W'(1);
  assign imem_addr = pc_q;

  always_comb begin
    two_word = 1'b0;
    unique case (imem_data[15:11])
      5'b00111, 5'b01110, 5'b01111, 5'b10100, 5'b10101: two_word = 1'b1;
      default:                                           two_word = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      state_q   <= StFetch1;
      hold_q    <= NOP_WORD;
      instr_q   <= NOP_WORD;
      imm_q     <= '0;
      ifid_pc_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush) begin
      // Redirect drops any half-assembled instruction; ifid_pc keeps its last value.
      pc_q    <= branch_target;
      state_q <= StFetch1;
      hold_q  <= NOP_WORD;
      instr_q <= NOP_WORD;
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      pc_q <= pc_inc;
      unique case (state_q)
        StFetch1: begin
          if (two_word) begin
            hold_q  <= imem_data;
            state_q <= StFetch2;
            instr_q <= NOP_WORD;
            imm_q   <= '0;
            valid_q <= 1'b0;
          end else begin
            instr_q   <= imem_data;
            imm_q     <= '0;
            ifid_pc_q <= pc_inc;
            valid_q   <= 1'b1;
          end
        end
        StFetch2: begin
          // Immediate word is taken verbatim, never opcode-decoded.
          instr_q   <= hold_q;
          imm_q     <= imem_data;
          ifid_pc_q <= pc_inc;
          valid_q   <= 1'b1;
          state_q   <= StFetch1;
        end
        default: state_q <= StFetch1;
      endcase
    end
  end

  assign ifid_instr = instr_q;
  assign ifid_imm   = imm_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: instruction-level reference model checked every cycle,
// directed scenarios pinned with literal values, then randomized stimulus.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [15:0] branch_target;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] ifid_instr, ifid_imm, ifid_pc;
  logic        ifid_valid;

  logic [15:0] mem [65536];
  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: word-stream view of the program.
  logic [15:0] m_pc, m_hold;
  bit          m_mid;  // previous consumed word opened a two-word instruction
  logic [15:0] e_instr, e_imm, e_pc;
  logic        e_valid;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .ifid_instr    (ifid_instr),
    .ifid_imm      (ifid_imm),
    .ifid_pc       (ifid_pc),
    .ifid_valid    (ifid_valid)
  );

  function automatic bit is_two(input logic [15:0] w);
    return w[15:11] inside {5'b00111, 5'b01110, 5'b01111, 5'b10100, 5'b10101};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [15:0] w;
    if (rst) begin
      m_pc = 16'h0000; m_mid = 1'b0; m_hold = 16'hF800;
      e_instr = 16'hF800; e_imm = 16'h0; e_pc = 16'h0; e_valid = 1'b0;
    end else if (flush) begin
      m_pc = branch_target; m_mid = 1'b0;
      e_instr = 16'hF800; e_imm = 16'h0; e_valid = 1'b0;
    end else if (!stall) begin
      w = mem[m_pc];
      if (m_mid) begin
        e_instr = m_hold; e_imm = w; e_pc = m_pc + 16'd1; e_valid = 1'b1; m_mid = 1'b0;
      end else if (is_two(w)) begin
        m_hold = w; m_mid = 1'b1;
        e_instr = 16'hF800; e_imm = 16'h0; e_valid = 1'b0;
      end else begin
        e_instr = w; e_imm = 16'h0; e_pc = m_pc + 16'd1; e_valid = 1'b1;
      end
      m_pc = m_pc + 16'd1;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic cycle(input logic r, input logic f, input logic s, input logic [15:0] bt);
    rst = r; flush = f; stall = s; branch_target = bt;
    @(posedge clk);
    model_step();
    #1;
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_valid", {15'b0, ifid_valid}, {15'b0, e_valid});
    chk("ifid_instr", ifid_instr, e_instr);
    chk("ifid_imm", ifid_imm, e_imm);
    if (e_valid) chk("ifid_pc", ifid_pc, e_pc);
  endtask

  task automatic lit(input string name, input logic [15:0] instr, input logic [15:0] imm,
                     input logic [15:0] pc, input logic valid, input logic [15:0] addr);
    chk({name, ".addr"}, imem_addr, addr);
    chk({name, ".valid"}, {15'b0, ifid_valid}, {15'b0, valid});
    chk({name, ".instr"}, ifid_instr, instr);
    chk({name, ".imm"}, ifid_imm, imm);
    if (valid) chk({name, ".pc"}, ifid_pc, pc);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; branch_target = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0000; mem[1] = 16'h2800; mem[2] = 16'hC800;
    mem[3] = 16'h3800; mem[4] = 16'h1234; mem[5] = 16'h0000;
    mem[6] = 16'h3800; mem[7] = 16'h5555; mem[16'h0040] = 16'h2800;

    cycle(1, 0, 0, 16'h0);
    cycle(1, 0, 0, 16'h0);
    chk("reset.ifid_pc", ifid_pc, 16'h0000);
    lit("reset", 16'hF800, 16'h0, 16'h0, 1'b0, 16'h0000);

    cycle(0, 0, 0, 16'h0); lit("add", 16'h0000, 16'h0, 16'h0001, 1'b1, 16'h0001);
    cycle(0, 0, 0, 16'h0); lit("mov", 16'h2800, 16'h0, 16'h0002, 1'b1, 16'h0002);
    cycle(0, 0, 0, 16'h0); lit("jn", 16'hC800, 16'h0, 16'h0003, 1'b1, 16'h0003);
    cycle(0, 0, 0, 16'h0); lit("ldm_bubble", 16'hF800, 16'h0, 16'h0, 1'b0, 16'h0004);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 16'h0); lit("stall_f2", 16'hF800, 16'h0, 16'h0, 1'b0, 16'h0004);
    end
    cycle(0, 0, 0, 16'h0); lit("ldm", 16'h3800, 16'h1234, 16'h0005, 1'b1, 16'h0005);
    cycle(0, 0, 0, 16'h0); lit("add2", 16'h0000, 16'h0, 16'h0006, 1'b1, 16'h0006);
    cycle(0, 0, 0, 16'h0); lit("ldm2_bubble", 16'hF800, 16'h0, 16'h0, 1'b0, 16'h0007);
    cycle(0, 1, 1, 16'h0040); lit("flush_stall", 16'hF800, 16'h0, 16'h0, 1'b0, 16'h0040);
    chk("flush.ifid_pc_kept", ifid_pc, 16'h0006);
    cycle(0, 0, 0, 16'h0); lit("after_flush", 16'h2800, 16'h0, 16'h0041, 1'b1, 16'h0041);

    mem[16'hFFFF] = 16'h7000; mem[0] = 16'hABCD;
    cycle(0, 1, 0, 16'hFFFF); lit("to_top", 16'hF800, 16'h0, 16'h0, 1'b0, 16'hFFFF);
    cycle(0, 0, 0, 16'h0); lit("wrap_bubble", 16'hF800, 16'h0, 16'h0, 1'b0, 16'h0000);
    cycle(0, 0, 0, 16'h0); lit("wrap_ldd", 16'h7000, 16'hABCD, 16'h0001, 1'b1, 16'h0001);

    // Randomized phase; mostly advancing, occasional hazards and redirects.
    for (int i = 0; i < 4000; i++) begin
      logic r, f, s;
      logic [15:0] bt;
      r  = ($urandom_range(0, 99) < 2);
      f  = ($urandom_range(0, 99) < 7);
      s  = ($urandom_range(0, 99) < 15);
      bt = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      cycle(r, f, s, bt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
